// File: rtl/fft_mag_peak_pkg.sv
// fft_mag_peak_pkg
//   Shared definitions for the FFT magnitude/peak block.
//   - DEF_OPD_DW / DEF_POINTS_LOG follow the FFT core's width/points defines
//     (FFT_OPD_DW, FFT_POINTS_LOG) when present, else 16 / 8.
//   - mag_width(): squared-magnitude width derived from the component width.
//   - state_t: frame FSM encoding (IDLE=0, CAPT=1, DRAIN=2, DONE=3).
`ifndef FFT_OPD_DW
`define FFT_OPD_DW 16
`endif

`ifndef FFT_POINTS_LOG
`define FFT_POINTS_LOG 8
`endif

package fft_mag_peak_pkg;

  localparam int DEF_OPD_DW     = `FFT_OPD_DW;
  localparam int DEF_POINTS_LOG = `FFT_POINTS_LOG;

  // re^2 + im^2 of two's-complement values needs one bit more than a product.
  function automatic int mag_width(input int opd_dw);
    return 2 * opd_dw + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fft_mag_peak_if.sv
// fft_mag_peak_if
//   FFT output stream bundle.
//   soud  : start-of-output pulse (with first opd beat)
//   opd   : data-valid qualifier for idx/xk_re/xk_im
//   eoud  : end-of-output pulse (with last opd beat)
//   idx   : bin index
//   xk_re : signed real part
//   xk_im : signed imaginary part
//   Modports: master = FFT core (drives), slave = consumer.
interface fft_mag_peak_if
  import fft_mag_peak_pkg::*;
#(
  parameter int OPD_DW     = DEF_OPD_DW,
  parameter int POINTS_LOG = DEF_POINTS_LOG
);
  logic                         soud;
  logic                         opd;
  logic                         eoud;
  logic        [POINTS_LOG-1:0] idx;
  logic signed [OPD_DW-1:0]     xk_re;
  logic signed [OPD_DW-1:0]     xk_im;

  modport master (output soud, opd, eoud, idx, xk_re, xk_im);
  modport slave  (input  soud, opd, eoud, idx, xk_re, xk_im);
endinterface

// File: rtl/fft_mag_peak_mag_sq.sv
// fft_mag_sq
//   Two-stage squared-magnitude pipeline.
//   S1 registers re*re and im*im (signed, 2*DW wide); S2 registers their
//   unsigned sum (MAG_W wide). valid and tag travel alongside.
//   Ports: clk, rst_n (async, active low), re, im, valid, tag in;
//          mag, mag_valid, mag_tag out (2-cycle latency).
module fft_mag_sq
  import fft_mag_peak_pkg::*;
#(
  parameter int DW    = DEF_OPD_DW,
  parameter int TAG_W = DEF_POINTS_LOG + 1,
  parameter int MAG_W = mag_width(DW)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] re,
  input  logic signed [DW-1:0] im,
  input  logic                 valid,
  input  logic [TAG_W-1:0]     tag,
  output logic [MAG_W-1:0]     mag,
  output logic                 mag_valid,
  output logic [TAG_W-1:0]     mag_tag
);
  localparam int PW = 2 * DW;

  logic signed [PW-1:0] re_ext;
  logic signed [PW-1:0] im_ext;
  logic signed [PW-1:0] re_sq_reg;
  logic signed [PW-1:0] im_sq_reg;
  logic                 s1_valid_reg;
  logic [TAG_W-1:0]     s1_tag_reg;
  logic [MAG_W-1:0]     re_sq_u;
  logic [MAG_W-1:0]     im_sq_u;

  // Sign-extend first so the product is computed at full width.
  assign re_ext = {{DW{re[DW-1]}}, re};
  assign im_ext = {{DW{im[DW-1]}}, im};

  // Squares are never negative, so zero-extension into the sum is exact;
  // (-2^(DW-1))^2 = 2^(2DW-2) still fits the signed product.
  assign re_sq_u = MAG_W'($unsigned(re_sq_reg));
  assign im_sq_u = MAG_W'($unsigned(im_sq_reg));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      re_sq_reg    <= '0;
      im_sq_reg    <= '0;
      s1_valid_reg <= 1'b0;
      s1_tag_reg   <= '0;
      mag          <= '0;
      mag_valid    <= 1'b0;
      mag_tag      <= '0;
    end else begin
      re_sq_reg    <= re_ext * re_ext;
      im_sq_reg    <= im_ext * im_ext;
      s1_valid_reg <= valid;
      s1_tag_reg   <= tag;
      mag          <= re_sq_u + im_sq_u;
      mag_valid    <= s1_valid_reg;
      mag_tag      <= s1_tag_reg;
    end
  end
endmodule

// File: rtl/fft_mag_peak.sv
// fft_mag_peak
//   Consumes the FFT output stream, writes |X[k]|^2 into a frame buffer
//   indexed by bin, tracks the peak bin, and holds the finished frame for a
//   host readout until frame_ack.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     fft (slave)         soud/opd/eoud/idx/xk_re/xk_im stream
//     rd_addr -> rd_data  registered buffer read, 1-cycle latency
//     frame_valid         completed frame held (DONE state)
//     frame_ack           host release, honoured only in DONE
//     peak_idx, peak_mag  maximum-magnitude bin of the frame
//     overflow            sticky: frame dropped while DONE; cleared by ack
//   Option: FFT_MAG_DC_SKIP_EN excludes bin 0 from the peak search (bin 0 is
//   still written to the buffer).
module fft_mag_peak
  import fft_mag_peak_pkg::*;
#(
  parameter int OPD_DW     = DEF_OPD_DW,
  parameter int POINTS_LOG = DEF_POINTS_LOG,
  parameter int MAG_DW     = mag_width(OPD_DW)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fft_mag_peak_if.slave         fft,
  input  logic [POINTS_LOG-1:0] rd_addr,
  output logic [MAG_DW-1:0]     rd_data,
  output logic                  frame_valid,
  input  logic                  frame_ack,
  output logic [POINTS_LOG-1:0] peak_idx,
  output logic [MAG_DW-1:0]     peak_mag,
  output logic                  overflow
);
  localparam int DEPTH = 1 << POINTS_LOG;
  localparam int TAG_W = POINTS_LOG + 1;   // {eoud, idx}

  state_t                  state_reg, state_next;
  logic                    start_beat;
  logic                    accept;
  logic                    clear_peak;
  logic                    ovf_set;
  logic                    ack_done;
  logic [MAG_DW-1:0]       mag;
  logic                    mag_valid;
  logic [TAG_W-1:0]        mag_tag;
  logic [POINTS_LOG-1:0]   wr_idx;
  logic                    wr_eoud;
  logic                    wr_en;
  logic                    peak_cand;
  logic [POINTS_LOG-1:0]   peak_idx_reg;
  logic [MAG_DW-1:0]       peak_mag_reg;
  logic                    overflow_reg;
  logic [MAG_DW-1:0]       mem [DEPTH];

  assign start_beat = fft.soud & fft.opd;

  fft_mag_sq #(
    .DW    (OPD_DW),
    .TAG_W (TAG_W),
    .MAG_W (MAG_DW)
  ) u_mag_sq (
    .clk       (clk),
    .rst_n     (rst_n),
    .re        (fft.xk_re),
    .im        (fft.xk_im),
    .valid     (accept),
    .tag       ({fft.eoud, fft.idx}),
    .mag       (mag),
    .mag_valid (mag_valid),
    .mag_tag   (mag_tag)
  );

  assign wr_idx  = mag_tag[POINTS_LOG-1:0];
  assign wr_eoud = mag_tag[POINTS_LOG];
  assign wr_en   = mag_valid && (state_reg != ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    clear_peak = 1'b0;
    ovf_set    = 1'b0;
    ack_done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_beat) begin
          accept     = 1'b1;
          clear_peak = 1'b1;
          // A single-beat frame carries eoud on its only beat.
          state_next = fft.eoud ? ST_DRAIN : ST_CAPT;
        end
      end
      ST_CAPT: begin
        // A repeated soud here is just another beat of the running frame.
        if (fft.opd) begin
          accept = 1'b1;
          if (fft.eoud) state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The last beat is being written this cycle.
        if (wr_en && wr_eoud) state_next = ST_DONE;
      end
      ST_DONE: begin
        // Ack takes priority; a coincident new frame is dropped silently.
        if (frame_ack) begin
          ack_done   = 1'b1;
          state_next = ST_IDLE;
        end else if (start_beat) begin
          ovf_set = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Strict compare: on a tie the earlier-written bin keeps the peak.
`ifdef FFT_MAG_DC_SKIP_EN
  assign peak_cand = wr_en && (wr_idx != '0) && (mag > peak_mag_reg);
`else
  assign peak_cand = wr_en && (mag > peak_mag_reg);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_idx_reg <= '0;
      peak_mag_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (clear_peak) begin
        peak_idx_reg <= '0;
        peak_mag_reg <= '0;
      end else if (peak_cand) begin
        peak_idx_reg <= wr_idx;
        peak_mag_reg <= mag;
      end
      if (ack_done)     overflow_reg <= 1'b0;
      else if (ovf_set) overflow_reg <= 1'b1;
    end
  end

  // Frame buffer: simple dual-port, write at S2, registered read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

  assign frame_valid = (state_reg == ST_DONE);
  assign peak_idx    = peak_idx_reg;
  assign peak_mag    = peak_mag_reg;
  assign overflow    = overflow_reg;
endmodule

// File: tb/tb_fft_mag_peak.sv
// tb_fft_mag_peak
//   Directed-vector bench for fft_mag_peak. Inputs are driven on the falling
//   edge, outputs sampled on the falling edge (away from the rising edge).
module tb_fft_mag_peak;
  localparam int OPD_DW = 16;
  localparam int PL     = 8;
  localparam int MAG_DW = 33;
  localparam int N      = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_mag_peak_if #(.OPD_DW(OPD_DW), .POINTS_LOG(PL)) fft_bus ();

  logic [PL-1:0]     rd_addr;
  logic [MAG_DW-1:0] rd_data;
  logic              frame_valid;
  logic              frame_ack;
  logic [PL-1:0]     peak_idx;
  logic [MAG_DW-1:0] peak_mag;
  logic              overflow;

  fft_mag_peak #(.OPD_DW(OPD_DW), .POINTS_LOG(PL), .MAG_DW(MAG_DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fft         (fft_bus.slave),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .peak_idx    (peak_idx),
    .peak_mag    (peak_mag),
    .overflow    (overflow)
  );

  int checks = 0;
  int errors = 0;
  logic signed [OPD_DW-1:0] re_arr [N];
  logic signed [OPD_DW-1:0] im_arr [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_bins();
    for (int i = 0; i < N; i++) begin
      re_arr[i] = '0;
      im_arr[i] = '0;
    end
  endtask

  task automatic idle_bus();
    fft_bus.soud  = 1'b0;
    fft_bus.opd   = 1'b0;
    fft_bus.eoud  = 1'b0;
    fft_bus.idx   = '0;
    fft_bus.xk_re = '0;
    fft_bus.xk_im = '0;
  endtask

  // Sends bins 0..nbeats-1; if abort_at >= 0, asserts reset at that beat.
  task automatic send_frame(input int nbeats, input int abort_at);
    for (int i = 0; i < nbeats; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        idle_bus();
        rst_n = 1'b0;
        return;
      end
      fft_bus.soud  = (i == 0);
      fft_bus.eoud  = (i == nbeats - 1);
      fft_bus.opd   = 1'b1;
      fft_bus.idx   = PL'(i);
      fft_bus.xk_re = re_arr[i];
      fft_bus.xk_im = im_arr[i];
    end
    @(negedge clk);
    idle_bus();
  endtask

  // Called right after send_frame: frame_valid must rise exactly 2 edges after eoud.
  task automatic check_latency(input string tag);
    check_eq({tag, "_fv_e0"}, frame_valid, 1'b0);
    @(negedge clk);
    check_eq({tag, "_fv_e1"}, frame_valid, 1'b0);
    @(negedge clk);
    check_eq({tag, "_fv_e2"}, frame_valid, 1'b1);
  endtask

  task automatic rd_check(input string tag, input int addr, input logic [63:0] exp);
    @(negedge clk);
    rd_addr = PL'(addr);
    @(negedge clk);
    check_eq(tag, rd_data, exp);
  endtask

  task automatic ack();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic report(input string name);
    $display("frame %s: frame_valid=%0d peak_idx=%0d peak_mag=%0d overflow=%0d",
             name, frame_valid, peak_idx, peak_mag, overflow);
  endtask

  initial begin
    idle_bus();
    rd_addr   = '0;
    frame_ack = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_fv", frame_valid, 1'b0);
    check_eq("rst_ovf", overflow, 1'b0);
    check_eq("rst_pidx", peak_idx, 0);
    check_eq("rst_pmag", peak_mag, 0);
    check_eq("rst_rd", rd_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Ramp: re = idx, im = 0
    for (int i = 0; i < N; i++) begin
      re_arr[i] = OPD_DW'(i);
      im_arr[i] = '0;
    end
    send_frame(N, -1);
    check_latency("ramp");
    report("ramp");
    rd_check("ramp_rd10", 10, 100);
    rd_check("ramp_rd255", 255, 65025);
    check_eq("ramp_pidx", peak_idx, 255);
    check_eq("ramp_pmag", peak_mag, 65025);
    ack();
    check_eq("ramp_ack_fv", frame_valid, 1'b0);

    // Bin 37 = 3-4j (mag 25); bin 40 = 5 ties and must not take the peak
    clear_bins();
    re_arr[37] = 16'sd3;
    im_arr[37] = -16'sd4;
    re_arr[40] = 16'sd5;
    send_frame(N, -1);
    check_latency("b37");
    report("b37");
    rd_check("b37_rd37", 37, 25);
    rd_check("b37_rd38", 38, 0);
    check_eq("b37_pidx", peak_idx, 37);
    check_eq("b37_pmag", peak_mag, 25);
    ack();

    // Extreme value at bin 5
    clear_bins();
    re_arr[5] = -16'sd32768;
    im_arr[5] = -16'sd32768;
    send_frame(N, -1);
    check_latency("ext");
    report("ext");
    rd_check("ext_rd5", 5, 64'h0_8000_0000);
    check_eq("ext_pidx", peak_idx, 5);
    check_eq("ext_pmag", peak_mag, 64'h0_8000_0000);

    // Second frame while DONE, no ack: dropped, overflow set
    for (int i = 0; i < N; i++) re_arr[i] = OPD_DW'(i);
    clear_bins();
    for (int i = 0; i < N; i++) re_arr[i] = OPD_DW'(i);
    send_frame(N, -1);
    repeat (3) @(negedge clk);
    report("ovf");
    check_eq("ovf_set", overflow, 1'b1);
    check_eq("ovf_fv", frame_valid, 1'b1);
    rd_check("ovf_rd5", 5, 64'h0_8000_0000);
    check_eq("ovf_pidx", peak_idx, 5);
    ack();
    check_eq("ovf_ack_fv", frame_valid, 1'b0);
    check_eq("ovf_ack_ovf", overflow, 1'b0);
    // Ack in IDLE must be harmless
    ack();
    check_eq("idle_ack_fv", frame_valid, 1'b0);

    // DC vs bin 9: bin 0 mag 400, bin 9 mag 100
    clear_bins();
    re_arr[0] = 16'sd20;
    re_arr[9] = 16'sd10;
    send_frame(N, -1);
    check_latency("dc");
    report("dc");
    rd_check("dc_rd0", 0, 400);
`ifdef FFT_MAG_DC_SKIP_EN
    check_eq("dc_pidx", peak_idx, 9);
    check_eq("dc_pmag", peak_mag, 100);
`else
    check_eq("dc_pidx", peak_idx, 0);
    check_eq("dc_pmag", peak_mag, 400);
`endif
    ack();

    // Single-beat frame: bin 0 = 6+8j (mag 100)
    clear_bins();
    re_arr[0] = 16'sd6;
    im_arr[0] = 16'sd8;
    send_frame(1, -1);
    check_latency("one");
    report("one");
    rd_check("one_rd0", 0, 100);
`ifdef FFT_MAG_DC_SKIP_EN
    check_eq("one_pmag", peak_mag, 0);
`else
    check_eq("one_pmag", peak_mag, 100);
`endif
    check_eq("one_pidx", peak_idx, 0);

    // Ack coincident with a new single-beat frame in DONE: ack wins, frame dropped
    @(negedge clk);
    fft_bus.soud  = 1'b1;
    fft_bus.opd   = 1'b1;
    fft_bus.eoud  = 1'b1;
    fft_bus.idx   = 8'd3;
    fft_bus.xk_re = 16'sd1;
    frame_ack     = 1'b1;
    @(negedge clk);
    idle_bus();
    frame_ack = 1'b0;
    check_eq("race_fv", frame_valid, 1'b0);
    check_eq("race_ovf", overflow, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("race_fv_late", frame_valid, 1'b0);

    // Reset mid-capture at bin 100 of a large-valued frame
    clear_bins();
    for (int i = 0; i < N; i++) re_arr[i] = 16'sd100;
    send_frame(N, 100);
    #1;
    check_eq("mid_rst_fv", frame_valid, 1'b0);
    check_eq("mid_rst_pidx", peak_idx, 0);
    check_eq("mid_rst_pmag", peak_mag, 0);
    check_eq("mid_rst_rd", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_bins();
    re_arr[37] = 16'sd3;
    im_arr[37] = -16'sd4;
    send_frame(N, -1);
    check_latency("post_rst");
    report("post_rst");
    check_eq("post_rst_pidx", peak_idx, 37);
    check_eq("post_rst_pmag", peak_mag, 25);
    rd_check("post_rst_rd37", 37, 25);
    ack();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_mag_peak.md
Name: fft_mag_peak

Overview:
- Downstream consumer of the FFT core's output stream (idx, xk_re, xk_im, soud, opd, eoud).
- Computes the squared magnitude of each bin and writes it into an internal frame buffer addressed by bin index.
- Tracks the peak bin and its magnitude, then holds the completed frame for a host-side readout port until acknowledged.

Parameters:
- OPD_DW, 16, FFT output component width (signed).
- POINTS_LOG, 8, log2 of points per frame; buffer depth is 2**POINTS_LOG.
- MAG_DW, 2*OPD_DW+1, squared-magnitude width; must not be overridden smaller.

Ports:
- clk  in  1  FFT clock; all logic is on this single clock.
- rst_n  in  1  asynchronous, active-low reset.
- soud  in  1  start-of-output pulse, coincident with the first opd beat.
- opd  in  1  output-data-valid qualifier for idx/xk_re/xk_im.
- eoud  in  1  end-of-output pulse, coincident with the last opd beat.
- idx  in  POINTS_LOG  bin index of the current beat.
- xk_re  in  OPD_DW  signed real part.
- xk_im  in  OPD_DW  signed imaginary part.
- rd_addr  in  POINTS_LOG  readout bin address.
- rd_data  out  MAG_DW  squared magnitude at rd_addr, 1-cycle latency.
- frame_valid  out  1  completed frame held; buffer and peak registers are stable.
- frame_ack  in  1  host release; single-cycle pulse, only honoured in DONE.
- peak_idx  out  POINTS_LOG  bin index of the maximum magnitude.
- peak_mag  out  MAG_DW  maximum magnitude.
- overflow  out  1  sticky: a frame arrived while DONE and was dropped; cleared by frame_ack.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; frame_valid, overflow, peak_idx, peak_mag and rd_data = 0. Buffer contents are undefined.
- Pipeline: S1 registers re*re and im*im (signed products, each 2*OPD_DW wide). S2 registers their unsigned sum (MAG_DW). idx, opd and eoud are delayed alongside. Write to the buffer occurs at S2, 2 cycles after the opd beat.
- FSM states:
  - IDLE: on soud&opd, clear the peak (peak_mag=0, peak_idx=0) and go to CAPT. The first beat enters the pipeline in the same cycle.
  - CAPT: every opd beat enters the pipeline. Beats with opd=0 are ignored. On eoud&opd, go to DRAIN.
  - DRAIN: wait until the delayed eoud leaves S2, i.e. 2 cycles after eoud. Then assert frame_valid and go to DONE.
  - DONE: buffer writes are blocked. On frame_ack, frame_valid=0, overflow=0, go to IDLE.
- Peak update at S2 write: update peak when mag > peak_mag (strict). Ties keep the lower-arrival bin.
- Boundary conditions:
  - soud with opd=0 is ignored.
  - soud while in CAPT/DRAIN is ignored; the frame continues, and a duplicated idx simply overwrites.
  - soud&opd while in DONE sets overflow=1 and drops the whole frame, including its eoud.
  - frame_ack outside DONE is ignored.
  - frame_ack in the same cycle as soud&opd in DONE: the ack wins, state goes to IDLE, and that frame is dropped without setting overflow.
  - A single-beat frame (soud&eoud&opd together) goes IDLE→DRAIN directly.
  - Arithmetic maximum: re=im=-2**(OPD_DW-1) gives 2**(2*OPD_DW-1); this fits MAG_DW with no wrap.
- Readout: rd_data is a registered synchronous read, valid in any state; content is guaranteed only while frame_valid=1.
- Reset mid-frame returns to IDLE; the next frame starts cleanly on soud.

Optional Feature:
- Macro: FFT_MAG_DC_SKIP_EN.
- Defined: beats with idx==0 are still written to the buffer but excluded from the peak comparison. peak_idx stays 0 only if every non-DC magnitude is 0.
- Undefined: all bins, including idx 0, participate in the peak search.

Decomposition:
- Shared package/include: POINTS_LOG and OPD_DW defaults (sourced from the existing FFT width/points defines), MAG_DW derivation, FSM state encodings (IDLE=0, CAPT=1, DRAIN=2, DONE=3).
- One sub-module: fft_mag_sq, the 2-stage squared-magnitude pipeline (inputs re, im, valid, tag; outputs mag, valid, tag).
- Buffer is inferred simple dual-port RAM inside the top module.

Test Plan:
- 256-bin frame with re=idx, im=0 -> frame_valid 2 cycles after eoud; rd_addr=10 gives rd_data=100 next cycle; peak_idx=255, peak_mag=65025.
- Frame with bin 37 re=3, im=-4, all other bins 0 -> rd(37)=25; peak_idx=37, peak_mag=25.
- Extreme value re=im=-32768 at bin 5 -> rd(5)=2147483648 (0x080000000, 33 bits); no wrap.
- Second frame sent while DONE, no ack -> overflow=1, buffer unchanged; frame_ack -> frame_valid=0, overflow=0, state IDLE.
- Bin 0 mag=400, bin 9 mag=100 -> peak_idx=0 without FFT_MAG_DC_SKIP_EN; peak_idx=9 with it.
- rst_n pulsed low mid-CAPT at bin 100, then a full new frame -> outputs 0 during reset; new frame completes with correct peak, no stale peak carried over.
